// File: rtl/stg_pkg.sv
// Shared game package for the shoot-em-up collision logic.
//   scan_state_t          : collision scan FSM states
//   BOSS_*                : boss hit-box offsets relative to the boss position
//                           (11-bit signed, lower bounds inclusive, upper exclusive)
//   HIT_R2_DEFAULT        : default exclusive squared-distance bullet hit threshold
//   INVULN_FRAMES_DEFAULT : default number of frames collision stays masked after a hit
package stg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        REPORT
    } scan_state_t;

    localparam logic signed [10:0] BOSS_X_LO = 11'sd11;
    localparam logic signed [10:0] BOSS_X_HI = 11'sd12;
    localparam logic signed [10:0] BOSS_Y_LO = 11'sd19;
    localparam logic signed [10:0] BOSS_Y_HI = 11'sd20;

    localparam int unsigned HIT_R2_DEFAULT        = 60;
    localparam int unsigned INVULN_FRAMES_DEFAULT = 90;

endpackage

// File: rtl/dist2_cmp.sv
// Combinational squared-distance comparator between a bullet and the player.
//   ax, ay : player position (10-bit unsigned)
//   bx, by : bullet position (10-bit unsigned)
//   hit    : 1 when dx*dx + dy*dy < HIT_R2
module dist2_cmp
    import stg_pkg::*;
#(
    parameter int unsigned HIT_R2 = HIT_R2_DEFAULT
) (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    output logic       hit
);

    logic signed [10:0] dx, dy;
    logic signed [10:0] ndx, ndy;
    logic [9:0]         adx, ady;
    logic [20:0]        sqx, sqy;
    logic [21:0]        sum;

    always_comb begin
        dx  = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dy  = $signed({1'b0, by}) - $signed({1'b0, ay});
        ndx = -dx;
        ndy = -dy;
        // Squaring the magnitude keeps the multiplier unsigned; |d| <= 1023 fits 10 bits.
        adx = dx[10] ? ndx[9:0] : dx[9:0];
        ady = dy[10] ? ndy[9:0] : dy[9:0];
        sqx = 21'(adx) * 21'(adx);
        sqy = 21'(ady) * 21'(ady);
        sum = 22'(sqx) + 22'(sqy);
        hit = (sum < 22'(HIT_R2));
    end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scheduler: scans the bullet table one slot per cycle,
// tests each valid bullet against the player, tests the player against the boss
// hit box, and reports the result with invulnerability masking.
//   clk, rst              : clock, synchronous active-high reset
//   frame_start           : one-cycle pulse starting (or restarting) a scan
//   player_x/y, hecatia_x/y : positions, latched at frame_start
//   rd_en, rd_addr        : bullet-table read strobe and slot address
//   bullet_valid/x/y      : slot data, returned one cycle after rd_en
//   busy                  : scan in progress (SCAN, DRAIN, REPORT)
//   done                  : one-cycle scan-complete pulse
//   collision             : one-cycle unmasked hit pulse (with done)
//   hit_boss, hit_any, hit_idx : scan result, held until the next report
//   invuln                : invulnerability counter nonzero
//   overrun               : one-cycle pulse when frame_start aborts a scan
module collision_scheduler
    import stg_pkg::*;
#(
    parameter int unsigned NUM_BULLETS   = 64,
    parameter int unsigned HIT_R2        = HIT_R2_DEFAULT,
    parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [9:0]                     player_x,
    input  logic [9:0]                     player_y,
    input  logic [9:0]                     hecatia_x,
    input  logic [9:0]                     hecatia_y,
    output logic                           rd_en,
    output logic [$clog2(NUM_BULLETS)-1:0] rd_addr,
    input  logic                           bullet_valid,
    input  logic [9:0]                     bullet_x,
    input  logic [9:0]                     bullet_y,
    output logic                           busy,
    output logic                           done,
    output logic                           collision,
    output logic                           hit_boss,
    output logic                           hit_any,
    output logic [$clog2(NUM_BULLETS)-1:0] hit_idx,
    output logic                           invuln,
    output logic                           overrun
);

    localparam int unsigned ADDR_W = $clog2(NUM_BULLETS);
    localparam int unsigned INV_W  = $clog2(INVULN_FRAMES + 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_BULLETS - 1);

    scan_state_t state_q, state_d;

    logic [9:0]        px_q, py_q, hx_q, hy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] eval_idx_q;
    logic              eval_en_q;
    logic              scan_hit_q;
    logic [ADDR_W-1:0] scan_idx_q;
    logic              hit_boss_q, hit_any_q;
    logic [ADDR_W-1:0] hit_idx_q;
    logic [INV_W-1:0]  inv_cnt_q;
    logic              overrun_q;

    logic              dist_hit;
    logic              slot_hit;
    logic              boss_hit;
    logic signed [10:0] bdx, bdy;

    dist2_cmp #(
        .HIT_R2(HIT_R2)
    ) u_dist2_cmp (
        .ax (px_q),
        .ay (py_q),
        .bx (bullet_x),
        .by (bullet_y),
        .hit(dist_hit)
    );

    // eval_en_q marks data belonging to a slot issued by the current scan, so
    // slots still in flight when a scan is restarted are ignored.
    assign slot_hit = eval_en_q && bullet_valid && dist_hit;

    // Boss box tested on the player-boss difference, which always fits 11-bit
    // signed, so neither bound can wrap near 0 or 1023.
    always_comb begin
        bdx      = $signed({1'b0, px_q}) - $signed({1'b0, hx_q});
        bdy      = $signed({1'b0, py_q}) - $signed({1'b0, hy_q});
        boss_hit = (bdx >= -BOSS_X_LO) && (bdx < BOSS_X_HI) &&
                   (bdy >= -BOSS_Y_LO) && (bdy < BOSS_Y_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        done      = 1'b0;
        collision = 1'b0;

        if (frame_start) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SCAN:    if (addr_q == LAST_SLOT) state_d = DRAIN;
                DRAIN:   state_d = REPORT;
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        rd_en = (state_q == SCAN);

        // A restart or reset landing on the report cycle suppresses the report.
        if (state_q == REPORT && !frame_start && !rst) begin
            done      = 1'b1;
            collision = (hit_boss_q || hit_any_q) && (inv_cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q       <= '0;
            py_q       <= '0;
            hx_q       <= '0;
            hy_q       <= '0;
            addr_q     <= '0;
            eval_idx_q <= '0;
            eval_en_q  <= 1'b0;
            scan_hit_q <= 1'b0;
            scan_idx_q <= '0;
            hit_boss_q <= 1'b0;
            hit_any_q  <= 1'b0;
            hit_idx_q  <= '0;
            inv_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= frame_start && busy;

            if (frame_start) begin
                px_q       <= player_x;
                py_q       <= player_y;
                hx_q       <= hecatia_x;
                hy_q       <= hecatia_y;
                addr_q     <= '0;
                eval_en_q  <= 1'b0;
                scan_hit_q <= 1'b0;
                scan_idx_q <= '0;
            end else begin
                eval_en_q  <= rd_en;
                eval_idx_q <= addr_q;
                if (state_q == SCAN) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (slot_hit && !scan_hit_q) begin
                    scan_hit_q <= 1'b1;
                    scan_idx_q <= eval_idx_q;
                end
                // The last slot is evaluated during DRAIN, so fold it in here.
                if (state_q == DRAIN) begin
                    hit_boss_q <= boss_hit;
                    hit_any_q  <= scan_hit_q || slot_hit;
                    if (scan_hit_q) begin
                        hit_idx_q <= scan_idx_q;
                    end else if (slot_hit) begin
                        hit_idx_q <= eval_idx_q;
                    end else begin
                        hit_idx_q <= '0;
                    end
                end
            end

            if (collision) begin
                inv_cnt_q <= INV_W'(INVULN_FRAMES);
            end else if (done && inv_cnt_q != '0) begin
                inv_cnt_q <= inv_cnt_q - INV_W'(1);
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_addr  = addr_q;
    assign hit_boss = hit_boss_q;
    assign hit_any  = hit_any_q;
    assign hit_idx  = hit_idx_q;
    assign invuln   = (inv_cnt_q != '0);
    assign overrun  = overrun_q;

endmodule
